// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux_scan_next_chan.sv
// Round-robin channel search: first set mask bit strictly after cur, wrapping 3->0.
// If only cur is set the result is cur; wrap flags that the search went past channel 3.
module mux_scan_next_chan
    import mux_scan_pkg::*;
(
    input  logic [3:0] mask_i,
    input  logic [1:0] cur_i,
    output logic [1:0] next_o,
    output logic       wrap_o,
    output logic       none_o
);

    logic [1:0] idx;
    logic       found;

    // Scan offsets 1..4 from cur; offset 4 lands back on cur itself.
    always_comb begin
        next_o = cur_i;
        found  = 1'b0;
        idx    = cur_i;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = cur_i + 2'(k);
            if (!found && mask_i[idx]) begin
                next_o = idx;
                found  = 1'b1;
            end
        end
        none_o = (mask_i == '0);
        wrap_o = (next_o <= cur_i);
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps the select lines over the enabled channels,
// waits a settle interval after every change, then samples the mux output.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_y,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output logic               sample_valid,
    output logic [1:0]         sample_chan,
    output logic               sample_data,
    output logic               frame_done,
    output logic [3:0]         snapshot
);

    state_e             state_q;
    logic [1:0]         chan_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               busy_q;
    logic               valid_q;
    logic [1:0]         schan_q;
    logic               sdata_q;
    logic               fdone_q;
    logic [3:0]         snap_q;

    logic [1:0]         next_chan_d;
    logic               wrap_d;
    logic               none_d;
    logic [1:0]         search_cur;

    // From IDLE, searching "after channel 3" yields the lowest enabled channel.
    always_comb begin
        search_cur = (state_q == ST_IDLE) ? CH_D : chan_q;
    end

    mux_scan_next_chan u_next (
        .mask_i (chan_mask),
        .cur_i  (search_cur),
        .next_o (next_chan_d),
        .wrap_o (wrap_d),
        .none_o (none_d)
    );

    // Scan FSM with dwell counter and registered strobes/results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            schan_q <= '0;
            sdata_q <= 1'b0;
            fdone_q <= 1'b0;
            snap_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            fdone_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop && !none_d) begin
                        chan_q  <= next_chan_d;
                        cnt_q   <= dwell;
                        dwell_q <= dwell;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    snap_q[chan_q] <= mux_y;
                    sdata_q        <= mux_y;
                    schan_q        <= chan_q;
                    valid_q        <= 1'b1;
                    if (none_d) begin
                        fdone_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        fdone_q <= wrap_d;
                        if (stop) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            chan_q  <= next_chan_d;
                            cnt_q   <= dwell_q;
                            state_q <= ST_SETTLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s0           = chan_q[1];
    assign s1           = chan_q[0];
    assign busy         = busy_q;
    assign sample_valid = valid_q;
    assign sample_chan  = schan_q;
    assign sample_data  = sdata_q;
    assign frame_done   = fdone_q;
    assign snapshot     = snap_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomised self-checking bench for mux_scan_ctrl against a schedule-based reference model.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop;
    logic [3:0] chan_mask;
    logic [7:0] dwell;
    logic       mux_y;
    logic       s0, s1, busy, sample_valid, sample_data, frame_done;
    logic [1:0] sample_chan;
    logic [3:0] snapshot;

    // Mux data inputs: bit0=a, bit1=b, bit2=c, bit3=d; the mux selects with {s0,s1}.
    logic [3:0] abcd;
    logic       rand_y;
    assign mux_y = abcd[{s0, s1}];

    always #5 clk = ~clk;

    mux_scan_ctrl #(.DWELL_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .chan_mask    (chan_mask),
        .dwell        (dwell),
        .mux_y        (mux_y),
        .s0           (s0),
        .s1           (s1),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .frame_done   (frame_done),
        .snapshot     (snapshot)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a scan is a schedule; edge number m_e counts edges since the
    // start edge, and every (dwell+2)-th edge is a sample edge.
    logic       m_busy;
    logic [1:0] m_chan;
    int         m_d, m_e;
    logic [3:0] m_snap;
    logic       m_valid, m_sdata, m_fd;
    logic [1:0] m_schan;

    function automatic logic [1:0] rr_after(input logic [3:0] m, input logic [1:0] c);
        int en[$];
        for (int i = 0; i < 4; i++) if (m[i]) en.push_back(i);
        foreach (en[j]) if (en[j] > int'(c)) return 2'(en[j]);
        return 2'(en[0]);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_chan = 0; m_d = 0; m_e = 0; m_snap = 0;
        m_valid = 0; m_sdata = 0; m_fd = 0; m_schan = 0;
    endtask

    task automatic model_edge();
        logic [1:0] nx;
        m_valid = 0;
        m_fd    = 0;
        if (!m_busy) begin
            if (start && !stop && chan_mask != 0) begin
                m_busy = 1;
                m_chan = rr_after(chan_mask, 2'd3);
                m_d    = int'(dwell);
                m_e    = 0;
            end
        end else begin
            m_e++;
            if (m_e == m_d + 2) begin
                m_valid = 1;
                m_schan = m_chan;
                m_sdata = abcd[m_chan];
                m_snap[m_chan] = m_sdata;
                if (chan_mask == 0) begin
                    m_fd   = 1;
                    m_busy = 0;
                end else begin
                    nx   = rr_after(chan_mask, m_chan);
                    m_fd = (nx <= m_chan);
                    if (stop) m_busy = 0;
                    else begin
                        m_chan = nx;
                        m_e    = 0;
                    end
                end
            end else if (stop) begin
                m_busy = 0;
            end
        end
    endtask

    // One clock: model steps with the DUT edge, outputs checked 1 time unit later,
    // then returns at the falling edge with fresh mux data.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("busy",  busy, m_busy);
        check("sel",   {s0, s1}, m_chan);
        check("valid", sample_valid, m_valid);
        check("fdone", frame_done, m_fd);
        check("schan", sample_chan, m_schan);
        check("sdata", sample_data, m_sdata);
        check("snap",  snapshot, m_snap);
        @(negedge clk);
        if (rand_y) abcd = 4'($urandom);
    endtask

    task automatic pulse_start();
        start = 1; cycle(); start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1; cycle(); stop = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},   {s0, s1}, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_schan"}, sample_chan, 0);
        check({tag, "_sdata"}, sample_data, 0);
        check({tag, "_fdone"}, frame_done, 0);
        check({tag, "_snap"},  snapshot, 0);
    endtask

    // Full-mask scan with a..d = 1,0,1,1, including start-to-sample latency.
    task automatic run_test1(input string tag);
        int lat;
        rand_y = 0; abcd = 4'b1101; chan_mask = 4'b1111; dwell = 8'd2;
        pulse_start();
        lat = 1;  // the start edge itself counts as edge 1
        while (!sample_valid && lat < 50) begin
            cycle();
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_first_chan"}, sample_chan, 0);
        repeat (16) cycle();
        check({tag, "_snapshot"}, snapshot, 4'b1101);
        pulse_stop();
        repeat (3) cycle();
        rand_y = 1;
    endtask

    initial begin
        int guard;
        rst_n = 0; start = 0; stop = 0; chan_mask = 0; dwell = 0; abcd = 0; rand_y = 1;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1;
        cycle();

        run_test1("t1");

        // Two alternating channels, zero dwell.
        chan_mask = 4'b1010; dwell = 0;
        pulse_start();
        repeat (12) cycle();
        pulse_stop();

        // Single channel: every sample closes a frame.
        chan_mask = 4'b0100; dwell = 1;
        pulse_start();
        repeat (12) cycle();
        pulse_stop();
        repeat (2) cycle();

        // Stop while settling on channel 2.
        chan_mask = 4'b1111; dwell = 3;
        pulse_start();
        guard = 0;
        while (!(m_busy && m_chan == 2 && m_e == 1) && guard < 100) begin cycle(); guard++; end
        check("reach_ch2", guard < 100, 1);
        pulse_stop();
        check("stop_settle_busy", busy, 0);
        repeat (3) cycle();

        // Stop landing on the sample edge.
        pulse_start();
        repeat (6) cycle();
        guard = 0;
        while (!(m_busy && m_e == m_d + 1) && guard < 100) begin cycle(); guard++; end
        pulse_stop();
        check("stop_sample_valid", sample_valid, 1);
        check("stop_sample_busy", busy, 0);
        repeat (3) cycle();

        // Start ignored for empty mask and for simultaneous stop.
        chan_mask = 0;
        pulse_start();
        check("mask0_busy", busy, 0);
        chan_mask = 4'b0011; start = 1; stop = 1; cycle(); start = 0; stop = 0;
        check("startstop_busy", busy, 0);

        // Mask cleared mid-scan.
        chan_mask = 4'b1111; dwell = 1;
        pulse_start();
        repeat (5) cycle();
        chan_mask = 0;
        guard = 0;
        while (busy && guard < 50) begin cycle(); guard++; end
        check("mask_clear_idle", guard < 50, 1);
        repeat (2) cycle();

        // Maximum dwell, one channel.
        chan_mask = 4'b1000; dwell = 8'hFF;
        pulse_start();
        repeat (600) cycle();
        pulse_stop();
        repeat (2) cycle();

        // Asynchronous reset in the middle of settling, then restart.
        chan_mask = 4'b1111; dwell = 2;
        pulse_start();
        repeat (2) cycle();
        #2 rst_n = 0;
        #1 check_reset_outputs("async");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();
        run_test1("t6");

        // Random scans with mask changes, stray starts and occasional stops.
        for (int s = 0; s < 40; s++) begin
            chan_mask = 4'($urandom);
            dwell = 8'($urandom_range(0, 5));
            pulse_start();
            for (int c = 0; c < int'($urandom_range(5, 60)); c++) begin
                if ($urandom_range(0, 9) == 0) chan_mask = 4'($urandom);
                if ($urandom_range(0, 7) == 0) dwell = 8'($urandom);
                start = ($urandom_range(0, 5) == 0);
                stop  = ($urandom_range(0, 30) == 0);
                cycle();
                start = 0; stop = 0;
            end
            pulse_stop();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
